usc_rv_fetch: RTL and testbench
===============================

USC_RV_FETCH -- requirements
Module: usc_rv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, the first fetch address after reset; bits [2:0] are ignored.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port branch_req_i, input, 1, redirect request from the back end.
REQ-005 SHALL have port branch_pc_i, input, 32, redirect target.
REQ-006 SHALL have port icache_rd_o, output, 1, instruction-memory read request.
REQ-007 SHALL have port icache_pc_o, output, 32, request address, always 8-byte aligned.
REQ-008 SHALL have port icache_accept_i, input, 1, the request was taken this cycle.
REQ-009 SHALL have port icache_valid_i, input, 1, response data valid.
REQ-010 SHALL have port icache_inst_i, input, 64, response: two instructions, [31:0] at the lower address.
REQ-011 SHALL have port icache_error_i, input, 1, fetch fault, qualified by icache_valid_i.
REQ-012 SHALL have port fetch_valid_o, output, 1, a packet is presented to decode.
REQ-013 SHALL have port fetch_instr_o, output, 64, packet instructions.
REQ-014 SHALL have port fetch_pc_o, output, 32, packet address, 8-byte aligned.
REQ-015 SHALL have port fetch_slot_vld_o, output, 2, per-slot valid: bit0 lower word, bit1 upper word.
REQ-016 SHALL have port fetch_fault_o, output, 1, the packet carries a fetch fault.
REQ-017 SHALL have port fetch_accept_i, input, 1, decode consumes the packet.

Function
REQ-018 SHALL implement states REQ, WAIT, FULL, DRAIN and HALT, with at most one icache request outstanding.
REQ-019 SHALL, in REQ, drive icache_rd_o=1 and icache_pc_o={pc_q[31:3],3'b0}; on icache_accept_i go to WAIT.
REQ-020 SHALL, in WAIT with icache_valid_i, capture the response into the output register and go to FULL; fetch_valid_o rises the following cycle (1-cycle latency).
REQ-021 SHALL, on capture, set fetch_pc_o={pc_q[31:3],3'b0} and fetch_slot_vld_o={1'b1,~pc_q[2]}, then set pc_q={pc_q[31:3]+1,3'b0}; the address wraps from 32'hFFFF_FFF8 to 0.
REQ-022 SHALL, on a captured response with icache_error_i=1, set fetch_fault_o=1, fetch_instr_o=64'b0 and fetch_slot_vld_o=2'b01.
REQ-023 SHALL hold all fetch_*_o outputs stable in FULL until fetch_valid_o && fetch_accept_i.
REQ-024 SHALL, on acceptance in FULL, deassert fetch_valid_o next cycle and go to REQ; if the accepted packet had the fault flag, go to HALT instead.
REQ-025 SHALL keep icache_rd_o=0 in HALT until branch_req_i.
REQ-026 SHALL give branch_req_i priority over all other events in every state: pc_q<=branch_pc_i, and fetch_valid_o=0 from the next cycle.
REQ-027 SHALL, on branch in WAIT without a same-cycle icache_valid_i, or in REQ with a same-cycle icache_accept_i, go to DRAIN; otherwise go to REQ.
REQ-028 SHALL, in DRAIN, discard the next icache_valid_i response without capture and then go to REQ; a branch in DRAIN updates pc_q and stays in DRAIN.
REQ-029 SHALL NOT let fetch_accept_i without fetch_valid_o change any state.

Reset
REQ-030 SHALL, while rstn_i=0, asynchronously force: state REQ, pc_q=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, fetch_slot_vld_o=0, fetch_fault_o=0, and no pending drain.
REQ-031 SHALL, on the first edge after rstn_i deasserts, assert icache_rd_o with icache_pc_o={RESET_PC[31:3],3'b0}.
REQ-032 SHALL, when reset is asserted mid-transaction, forget the outstanding request; any response arriving after reset is ignored until a request is issued.

Verification
REQ-033 SHALL be checked for reset fetch with RESET_PC=32'h100: cache accepts immediately, returns 64'hA_B 2 cycles later -> fetch_valid_o=1, fetch_pc_o=32'h100, slot_vld=2'b11; the next request is at 32'h108.
REQ-034 SHALL be checked for backpressure: fetch_accept_i=0 for 5 cycles -> outputs stable, icache_rd_o=0 throughout; on accept the next request appears the following cycle.
REQ-035 SHALL be checked for redirect during WAIT to 32'h204 -> the pending response is dropped, the next request is at 32'h200, and the delivered packet has slot_vld=2'b10.
REQ-036 SHALL be checked for fault: icache_error_i=1 on a response -> fault=1, instr=0, slot_vld=2'b01; after accept icache_rd_o stays 0 until branch_req_i.
REQ-037 SHALL be checked for wrap: pc_q=32'hFFFF_FFF8 -> after delivery the next request is at 32'h0.
REQ-038 SHALL be checked for branch with icache_valid_i in the same cycle in WAIT -> no packet is delivered, the state is REQ (not DRAIN), and the request goes to the branch target.

Source files
------------

// File: rtl/usc_rv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : usc_rv_fetch
// Brief    : Single-outstanding instruction fetch unit delivering 8-byte packets.
// Revision : 1.0 - initial release
// ============================================================================
module usc_rv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        branch_req_i,
  input  logic [31:0] branch_pc_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_slot_vld_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i
);

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FULL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [63:0] instr_q, instr_d;
  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  slot_q, slot_d;
  logic        fault_q, fault_d;
  logic        unused_pc_bits;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    fpc_d   = fpc_q;
    slot_d  = slot_q;
    fault_d = fault_q;

    if (branch_req_i) begin
      pc_d    = branch_pc_i;
      valid_d = 1'b0;
      // A request still in flight must have its response swallowed in DRAIN.
      if ((state_q == ST_WAIT  && !icache_valid_i) ||
          (state_q == ST_REQ   &&  icache_accept_i) ||
          (state_q == ST_DRAIN && !icache_valid_i)) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (icache_accept_i) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (icache_valid_i) begin
            valid_d = 1'b1;
            fpc_d   = {pc_q[31:3], 3'b000};
            fault_d = icache_error_i;
            instr_d = icache_error_i ? 64'd0 : icache_inst_i;
            slot_d  = icache_error_i ? 2'b01 : {1'b1, ~pc_q[2]};
            pc_d    = {pc_q[31:3] + 29'd1, 3'b000};
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (valid_q && fetch_accept_i) begin
            valid_d = 1'b0;
            state_d = fault_q ? ST_HALT : ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (icache_valid_i) state_d = ST_REQ;
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_REQ;
      pc_q    <= {RESET_PC[31:3], 3'b000};
      valid_q <= 1'b0;
      instr_q <= 64'd0;
      fpc_q   <= 32'd0;
      slot_q  <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
      slot_q  <= slot_d;
      fault_q <= fault_d;
    end
  end

  assign icache_rd_o      = (state_q == ST_REQ);
  assign icache_pc_o      = {pc_q[31:3], 3'b000};
  assign fetch_valid_o    = valid_q;
  assign fetch_instr_o    = instr_q;
  assign fetch_pc_o       = fpc_q;
  assign fetch_slot_vld_o = slot_q;
  assign fetch_fault_o    = fault_q;

  // Byte-offset bits below the slot select never influence fetching.
  assign unused_pc_bits = ^pc_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_usc_rv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_usc_rv_fetch
// Brief    : Scoreboard bench for usc_rv_fetch with a behavioural cache/decode model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usc_rv_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instr;
    logic [1:0]  slot;
    logic        fault;
  } pkt_t;

  logic        clk_i, rstn_i, branch_req_i;
  logic [31:0] branch_pc_i;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i, icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_slot_vld_o;
  logic        fetch_fault_o;
  logic        fetch_accept_i;

  usc_rv_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .branch_req_i     (branch_req_i),
    .branch_pc_i      (branch_pc_i),
    .icache_rd_o      (icache_rd_o),
    .icache_pc_o      (icache_pc_o),
    .icache_accept_i  (icache_accept_i),
    .icache_valid_i   (icache_valid_i),
    .icache_inst_i    (icache_inst_i),
    .icache_error_i   (icache_error_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_instr_o    (fetch_instr_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_slot_vld_o (fetch_slot_vld_o),
    .fetch_fault_o    (fetch_fault_o),
    .fetch_accept_i   (fetch_accept_i)
  );

  int total = 0;
  int bad   = 0;
  pkt_t sb[$];

  // Stimulus knobs shared between the directed sequence and the driver.
  bit          rnd_mode, d_br, d_fa, d_err, d_br_on_valid;
  logic [31:0] d_bpc;
  logic [63:0] d_data;
  int          d_lat;

  // Reference model state: architectural fetch pc and the single cache transaction.
  logic [31:0] exp_pc, req_pc;
  bit          outst, live, post_rst, halted;
  int          cnt, lat_sel;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin step(); n++; end while (!fetch_valid_o && n < 60);
    if (!fetch_valid_o) begin
      total++; bad++;
      $display("FAIL %s: fetch_valid_o got 0 want 1 within 60 cycles", nm);
    end
  endtask

  task automatic wait_rd(input string nm);
    int n = 0;
    do begin step(); n++; end while (!icache_rd_o && n < 60);
    if (!icache_rd_o) begin
      total++; bad++;
      $display("FAIL %s: icache_rd_o got 0 want 1 within 60 cycles", nm);
    end
  endtask

  // Driver + reference model: inputs chosen here are sampled by the next rising edge.
  initial begin
    pkt_t p;
    branch_req_i = 0; branch_pc_i = 0; icache_accept_i = 0; icache_valid_i = 0;
    icache_inst_i = 0; icache_error_i = 0; fetch_accept_i = 0;
    exp_pc = RST_PC; req_pc = 0; outst = 0; live = 0; post_rst = 0; halted = 0;
    cnt = 0; lat_sel = 0;
    forever begin
      @(negedge clk_i);
      branch_req_i = 0; icache_accept_i = 0; icache_valid_i = 0;
      icache_error_i = 0; icache_inst_i = 0; fetch_accept_i = 0;
      if (!rstn_i) begin
        sb.delete();
        exp_pc = {RST_PC[31:3], 3'b000};
        halted = 0; live = 0; post_rst = 0;
      end else begin
        if (icache_rd_o) chk("req_pc", 64'(icache_pc_o), 64'({exp_pc[31:3], 3'b000}));
        chk("rd_legal", 64'(icache_rd_o && ((outst && post_rst) || halted || fetch_valid_o)), 64'd0);

        if (outst) begin
          if (cnt == 0) begin
            icache_valid_i = 1;
            icache_inst_i  = rnd_mode ? {$urandom, $urandom} : d_data;
            icache_error_i = rnd_mode ? ($urandom_range(0, 19) == 0) : d_err;
            if (!rnd_mode && d_br_on_valid) begin
              branch_req_i = 1; branch_pc_i = d_bpc; d_br_on_valid = 0;
            end
          end else begin
            cnt--;
          end
        end
        if (rnd_mode) begin
          if ($urandom_range(0, 15) == 0) begin branch_req_i = 1; branch_pc_i = $urandom; end
          fetch_accept_i  = ($urandom_range(0, 9) < 7);
          icache_accept_i = icache_rd_o && !outst && ($urandom_range(0, 9) < 6);
          lat_sel         = $urandom_range(0, 3);
        end else begin
          if (d_br) begin branch_req_i = 1; branch_pc_i = d_bpc; d_br = 0; end
          fetch_accept_i  = d_fa;
          icache_accept_i = icache_rd_o && !outst;
          lat_sel         = d_lat;
        end

        if (icache_valid_i) begin
          if (live && !branch_req_i) begin
            p.pc    = {req_pc[31:3], 3'b000};
            p.fault = icache_error_i;
            p.instr = icache_error_i ? 64'd0 : icache_inst_i;
            p.slot  = icache_error_i ? 2'b01 : {1'b1, ~req_pc[2]};
            sb.push_back(p);
            exp_pc = {req_pc[31:3] + 29'd1, 3'b000};
          end
          outst = 0; live = 0;
        end
        if (fetch_valid_o && fetch_accept_i && !branch_req_i && sb.size() > 0 && sb[0].fault)
          halted = 1;
        if (icache_accept_i) begin
          outst = 1; live = 1; post_rst = 1; cnt = lat_sel; req_pc = exp_pc;
        end
        if (branch_req_i) begin
          live = 0; exp_pc = branch_pc_i; halted = 0; sb.delete();
        end
      end
    end
  end

  // Monitor: compares every consumed packet with the scoreboard and checks hold stability.
  initial begin
    pkt_t e;
    bit          hold;
    logic [63:0] s_instr;
    logic [34:0] s_meta;
    hold = 0; s_instr = 0; s_meta = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rstn_i) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(fetch_valid_o), 64'd1);
          chk("hold_instr", fetch_instr_o, s_instr);
          chk("hold_meta", 64'({fetch_pc_o, fetch_slot_vld_o, fetch_fault_o}), 64'(s_meta));
        end
        if (fetch_valid_o && fetch_accept_i && !branch_req_i) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL pkt_unexpected: got packet pc %h want no packet", fetch_pc_o);
          end else begin
            e = sb.pop_front();
            chk("pkt_instr", fetch_instr_o, e.instr);
            chk("pkt_meta", 64'({fetch_pc_o, fetch_slot_vld_o, fetch_fault_o}),
                64'({e.pc, e.slot, e.fault}));
          end
        end
        hold    = fetch_valid_o && !fetch_accept_i && !branch_req_i;
        s_instr = fetch_instr_o;
        s_meta  = {fetch_pc_o, fetch_slot_vld_o, fetch_fault_o};
      end
    end
  end

  initial begin
    logic [63:0] snap_i;
    logic [34:0] snap_m;
    rstn_i = 0; rnd_mode = 0; d_br = 0; d_bpc = 0; d_fa = 0; d_err = 0;
    d_lat = 1; d_data = 64'h0000_000A_0000_000B; d_br_on_valid = 0;

    step(); step();
    chk("rst_valid", 64'(fetch_valid_o), 64'd0);
    chk("rst_instr", fetch_instr_o, 64'd0);
    chk("rst_pc", 64'(fetch_pc_o), 64'd0);
    chk("rst_slot", 64'(fetch_slot_vld_o), 64'd0);
    chk("rst_fault", 64'(fetch_fault_o), 64'd0);
    rstn_i = 1;

    step();
    chk("boot_rd", 64'(icache_rd_o), 64'd1);
    chk("boot_pc", 64'(icache_pc_o), 64'h100);
    step(); step();
    chk("lat_not_yet", 64'(fetch_valid_o), 64'd0);
    step();
    chk("lat_valid", 64'(fetch_valid_o), 64'd1);
    chk("first_pc", 64'(fetch_pc_o), 64'h100);
    chk("first_slot", 64'(fetch_slot_vld_o), 64'd3);
    chk("first_instr", fetch_instr_o, 64'h0000_000A_0000_000B);

    snap_i = fetch_instr_o;
    snap_m = {fetch_pc_o, fetch_slot_vld_o, fetch_fault_o};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", fetch_instr_o, snap_i);
      chk("bp_meta", 64'({fetch_pc_o, fetch_slot_vld_o, fetch_fault_o}), 64'(snap_m));
      chk("bp_rd", 64'(icache_rd_o), 64'd0);
    end
    d_fa = 1; step(); d_fa = 0; step();
    chk("acc_drop", 64'(fetch_valid_o), 64'd0);
    chk("acc_next_rd", 64'(icache_rd_o), 64'd1);
    chk("acc_next_pc", 64'(icache_pc_o), 64'h108);

    // Redirect while the 0x108 request is still waiting for its response.
    d_bpc = 32'h204; d_br = 1;
    wait_rd("redir_rd");
    chk("redir_pc", 64'(icache_pc_o), 64'h200);
    d_fa = 1;
    wait_valid("redir_pkt");
    chk("redir_pkt_pc", 64'(fetch_pc_o), 64'h200);
    chk("redir_slot", 64'(fetch_slot_vld_o), 64'd2);

    d_err = 1;
    wait_valid("fault_pkt");
    chk("fault_flag", 64'(fetch_fault_o), 64'd1);
    chk("fault_instr", fetch_instr_o, 64'd0);
    chk("fault_slot", 64'(fetch_slot_vld_o), 64'd1);
    d_err = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("halt_rd", 64'(icache_rd_o), 64'd0);
    end

    d_bpc = 32'hFFFF_FFF8; d_br = 1;
    wait_rd("wrap_rd");
    chk("wrap_req_pc", 64'(icache_pc_o), 64'hFFFF_FFF8);
    wait_valid("wrap_pkt");
    chk("wrap_pkt_pc", 64'(fetch_pc_o), 64'hFFFF_FFF8);
    wait_rd("wrap_next_rd");
    chk("wrap_next_pc", 64'(icache_pc_o), 64'h0);

    // Branch arriving together with the response: no packet and no drain.
    d_bpc = 32'h340; d_br_on_valid = 1;
    begin
      int n = 0;
      do begin step(); n++; end while (!branch_req_i && n < 20);
    end
    step();
    chk("bv_no_pkt", 64'(fetch_valid_o), 64'd0);
    chk("bv_rd", 64'(icache_rd_o), 64'd1);
    chk("bv_pc", 64'(icache_pc_o), 64'h340);

    // Reset while the 0x340 request is outstanding; its late response must be ignored.
    step();
    rstn_i = 0;
    step(); step();
    chk("mid_rst_valid", 64'(fetch_valid_o), 64'd0);
    chk("mid_rst_pc", 64'(fetch_pc_o), 64'd0);
    rstn_i = 1;
    wait_valid("post_rst_pkt");
    chk("post_rst_pc", 64'(fetch_pc_o), 64'h100);

    rnd_mode = 1;
    repeat (4000) step();
    rnd_mode = 0; d_fa = 1; d_err = 0; d_lat = 1;
    d_bpc = 32'h500; d_br = 1;
    step(); step();
    wait_valid("final_pkt");
    chk("final_pc", 64'(fetch_pc_o), 64'h500);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
